// File: rtl/calc_pkg.sv
// Shared definitions for the calc_sequencer arithmetic controller:
// opcode encodings, FSM state type and counter sizing helper.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        DONE    = 2'd3
    } calc_state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// Shared iterative datapath: shift-add multiply (i_mode=0) or restoring
// divide (i_mode=1), one iteration per i_step.
module calc_iter_unit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_mode,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_result
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_b;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_rem_diff;

    // Multiply: partial product enters the top half and the whole
    // accumulator shifts right, so after WIDTH steps r_acc is the product.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_shift[0] ? {1'b0, r_b} : '0);
    // Divide: remainder lives in r_acc low half, quotient shifts in via r_shift.
    assign w_rem_sh   = {r_acc[WIDTH-1:0], r_shift[WIDTH-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_shift <= '0;
            r_b     <= '0;
        end else if (i_load) begin
            r_acc   <= '0;
            r_shift <= i_a;
            r_b     <= i_b;
        end else if (i_step) begin
            if (!i_mode) begin
                r_acc   <= {w_mul_sum, r_acc[WIDTH-1:1]};
                r_shift <= r_shift >> 1;
            end else if (!w_rem_diff[WIDTH]) begin
                r_acc   <= {{WIDTH{1'b0}}, w_rem_diff[WIDTH-1:0]};
                r_shift <= {r_shift[WIDTH-2:0], 1'b1};
            end else begin
                r_acc   <= {{WIDTH{1'b0}}, w_rem_sh[WIDTH-1:0]};
                r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign o_result = i_mode ? {r_acc[WIDTH-1:0], r_shift} : r_acc;

endmodule

// File: rtl/calc_sequencer.sv
// One-at-a-time arithmetic controller: ADD/SUB/DIV-by-zero resolve at accept,
// MUL/DIV run WIDTH iterations on the shared calc_iter_unit.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_value,
    output logic               res_flag
);

    localparam int CW = cnt_width(WIDTH);

    calc_state_t        r_state, w_next;
    logic [1:0]         r_op;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_res;
    logic               r_flag;
    logic               r_use_unit;

    logic               w_accept;
    logic               w_load;
    logic               w_step;
    logic               w_div_zero;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_unit_res;

    assign w_accept   = cmd_valid && (r_state == IDLE);
    assign w_div_zero = (cmd_b == '0);
    assign w_sum      = {1'b0, cmd_a} + {1'b0, cmd_b};

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_load = 1'b1;
                    case (cmd_op)
                        OP_MUL:  w_next = MUL_RUN;
                        OP_DIV:  w_next = w_div_zero ? DONE : DIV_RUN;
                        default: w_next = DONE;
                    endcase
                end
            end
            MUL_RUN, DIV_RUN: begin
                w_step = 1'b1;
                if (r_cnt == CW'(1)) w_next = DONE;
            end
            DONE: begin
                if (res_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= OP_ADD;
            r_cnt      <= '0;
            r_res      <= '0;
            r_flag     <= 1'b0;
            r_use_unit <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op       <= cmd_op;
                r_res      <= '0;
                r_flag     <= 1'b0;
                r_use_unit <= 1'b0;
                case (cmd_op)
                    OP_ADD: begin
                        r_res  <= {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
                        r_flag <= w_sum[WIDTH];
                    end
                    OP_SUB: begin
                        r_res  <= {{WIDTH{1'b0}}, cmd_a - cmd_b};
                        r_flag <= (cmd_a < cmd_b);
                    end
                    OP_MUL: begin
                        r_use_unit <= 1'b1;
                        r_cnt      <= CW'(WIDTH);
                    end
                    default: begin
                        if (w_div_zero) begin
                            r_res  <= {cmd_a, {WIDTH{1'b1}}};
                            r_flag <= 1'b1;
                        end else begin
                            r_use_unit <= 1'b1;
                            r_cnt      <= CW'(WIDTH);
                        end
                    end
                endcase
            end else if (w_step) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_mode   (r_op == OP_DIV),
        .i_a      (cmd_a),
        .i_b      (cmd_b),
        .o_result (w_unit_res)
    );

    assign cmd_ready = (r_state == IDLE);
    assign res_valid = (r_state == DONE);
    assign res_value = r_use_unit ? w_unit_res : r_res;
    assign res_flag  = r_flag;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed + random scoreboard bench for calc_sequencer (WIDTH=8).
module tb_calc_sequencer;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [W-1:0]   cmd_a;
    logic [W-1:0]   cmd_b;
    logic           res_valid;
    logic           res_ready;
    logic [2*W-1:0] res_value;
    logic           res_flag;

    typedef struct {
        logic [2*W-1:0] value;
        logic           flag;
        int             lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    calc_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_value (res_value),
        .res_flag  (res_flag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   ai, bi;
        ai = int'(a);
        bi = int'(b);
        e.flag = 1'b0;
        e.lat  = 1;
        case (op)
            2'd0: begin
                e.value = (2*W)'((ai + bi) % 256);
                e.flag  = (ai + bi) > 255;
            end
            2'd1: begin
                e.value = (2*W)'((ai - bi + 256) % 256);
                e.flag  = ai < bi;
            end
            2'd2: begin
                e.value = (2*W)'(ai * bi);
                e.lat   = W + 1;
            end
            default: begin
                if (bi == 0) begin
                    e.value = (2*W)'(ai * 256 + 255);
                    e.flag  = 1'b1;
                end else begin
                    e.value = (2*W)'((ai % bi) * 256 + ai / bi);
                    e.lat   = W + 1;
                end
            end
        endcase
        return e;
    endfunction

    // Present a command at a negedge, wait for it to be taken and return
    // after the accept edge (at the following negedge).
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int waitc;
        sb.push_back(model(op, a, b));
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        waitc = 0;
        while (!cmd_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("accept_wait", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pop the head of the scoreboard, compare, and complete the handshake.
    task automatic consume(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_value"}, 32'(res_value), 32'(e.value));
        check({tag, "_flag"}, 32'(res_flag), 32'(e.flag));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_idle_valid"}, 32'(res_valid), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int stall);
        int lat;
        issue(op, a, b);
        cmd_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(sb[0].lat));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, "_stall_valid"}, 32'(res_valid), 32'd1);
            check({tag, "_stall_value"}, 32'(res_value), 32'(sb[0].value));
        end
        consume(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_value", 32'(res_value), 32'd0);
        check("rst_res_flag", 32'(res_flag), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("add_carry", 2'd0, 8'd200, 8'd100, 0);
        run_op("sub_borrow", 2'd1, 8'd3, 8'd5, 0);
        run_op("mul_max", 2'd2, 8'd255, 8'd255, 0);
        run_op("mul_zero", 2'd2, 8'd0, 8'd17, 0);
        run_op("div_100_7", 2'd3, 8'd100, 8'd7, 0);
        run_op("div_zero", 2'd3, 8'd9, 8'd0, 0);
        run_op("add_max", 2'd0, 8'd255, 8'd255, 2);
        run_op("sub_eq", 2'd1, 8'd77, 8'd77, 1);
        run_op("div_small", 2'd3, 8'd5, 8'd200, 0);
        run_op("div_by1", 2'd3, 8'd255, 8'd1, 0);

        // Backpressure: result held with a second command pending on the port.
        issue(2'd0, 8'd10, 8'd20);
        cmd_op = 2'd1; cmd_a = 8'd50; cmd_b = 8'd8;
        check("bp_first_valid", 32'(res_valid), 32'd1);
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            check("bp_value", 32'(res_value), 32'd30);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        sb.push_back(model(2'd1, 8'd50, 8'd8));
        consume("bp_first");
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_second_valid", 32'(res_valid), 32'd1);
        consume("bp_second");

        // Reset in the middle of a divide discards it.
        issue(2'd3, 8'd100, 8'd7);
        void'(sb.pop_front());
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_value", 32'(res_value), 32'd0);
        check("mid_rst_flag", 32'(res_flag), 32'd0);
        run_op("post_rst_add", 2'd0, 8'd1, 8'd1, 0);

        for (int i = 0; i < 1000; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = W'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_op("rand", op, a, b, int'($urandom_range(0, 3)));
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
